// File: rtl/reg_scoreboard_if.sv
// Issue, write-back and flush bundle between the ID stage and the
// register scoreboard.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 15
);
  logic                issue_valid;
  logic [3:0]          src1;
  logic [3:0]          src2;
  logic                use_src2;
  logic [3:0]          dest;
  logic                dest_wb_en;
  logic                write_back_en;
  logic [3:0]          dest_wb;
  logic                flush_valid;
  logic [3:0]          flush_dest;
  logic                stall;
  logic                issue_ack;
  logic [NUM_REGS-1:0] busy_mask;
  logic [3:0]          inflight;
  logic                err_underflow;

  modport master (
    output issue_valid, src1, src2, use_src2,
    output dest, dest_wb_en,
    output write_back_en, dest_wb,
    output flush_valid, flush_dest,
    input  stall, issue_ack,
    input  busy_mask, inflight, err_underflow
  );

  modport slave (
    input  issue_valid, src1, src2, use_src2,
    input  dest, dest_wb_en,
    input  write_back_en, dest_wb,
    input  flush_valid, flush_dest,
    output stall, issue_ack,
    output busy_mask, inflight, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters; stalls ID issue on RAW hazards
// and on counter saturation. Index 15 (PC) is never tracked.
module reg_scoreboard #(
  parameter int NUM_REGS     = 15,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int WB_BYPASS    = 1
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);

  localparam int   UW     = CNT_W + 1;
  localparam logic BYPASS = (WB_BYPASS != 0);

  typedef logic [NUM_REGS-1:0] mask_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  cnt_t [NUM_REGS-1:0] count_q;
  cnt_t [NUM_REGS-1:0] count_d;
  mask_t               busy_q;
  mask_t               busy_d;
  logic [3:0]          inflight_q;
  logic [3:0]          inflight_d;
  logic                err_q;
  logic                err_d;

  mask_t src1_oh;
  mask_t src2_oh;
  mask_t dest_oh;
  mask_t wb_oh;
  mask_t fl_oh;
  mask_t inc_oh;
  mask_t rd_block;
  mask_t at_max;

  logic hazard1;
  logic hazard2;
  logic overflow;
  logic stall;
  logic issue_ack;

  // Out-of-range indices (incl. PC) decode to an empty mask.
  function automatic mask_t onehot(input logic [3:0] idx);
    mask_t v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    src1_oh = onehot(sb.src1);
    src2_oh = sb.use_src2 ? onehot(sb.src2) : '0;
    dest_oh = sb.dest_wb_en ? onehot(sb.dest) : '0;
    wb_oh   = sb.write_back_en ? onehot(sb.dest_wb) : '0;
    fl_oh   = sb.flush_valid ? onehot(sb.flush_dest) : '0;
  end

  // A single pending write being retired right now is bypassed
  // through the negedge register-file write.
  always_comb begin
    rd_block = '0;
    at_max   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_block[i] = (count_q[i] != '0) &&
                    !(BYPASS && wb_oh[i] &&
                      (count_q[i] == cnt_t'(1)));
      at_max[i]   = (count_q[i] == cnt_t'(MAX_INFLIGHT)) &&
                    !wb_oh[i] && !fl_oh[i];
    end
  end

  always_comb begin
    hazard1   = |(src1_oh & rd_block);
    hazard2   = |(src2_oh & rd_block);
    overflow  = |(dest_oh & at_max);
    stall     = sb.issue_valid & (hazard1 | hazard2 | overflow);
    issue_ack = sb.issue_valid & ~stall;
    inc_oh    = dest_oh & {NUM_REGS{issue_ack}};
  end

  always_comb begin
    logic [UW-1:0] up;
    logic [UW-1:0] dn;
    logic [7:0]    sum;
    count_d = count_q;
    busy_d  = '0;
    err_d   = err_q;
    sum     = '0;
    up      = '0;
    dn      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      up = UW'(count_q[i]) + UW'(inc_oh[i]);
      dn = UW'(wb_oh[i]) + UW'(fl_oh[i]);
      if (dn > up) begin
        count_d[i] = '0;
        err_d      = 1'b1;
      end else begin
        count_d[i] = cnt_t'(up - dn);
      end
      busy_d[i] = (count_d[i] != '0);
      sum       = sum + 8'(count_d[i]);
    end
    inflight_d = (sum > 8'd15) ? 4'hF : sum[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign sb.stall         = stall;
  assign sb.issue_ack     = issue_ack;
  assign sb.busy_mask     = busy_q;
  assign sb.inflight      = inflight_q;
  assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against a
// counter-array reference model.
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  int m_cnt[15];
  bit m_err;

  reg_scoreboard_if #(.NUM_REGS(15)) sb_if();

  reg_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .sb (sb_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_in();
    sb_if.issue_valid   = 1'b0;
    sb_if.src1          = 4'd0;
    sb_if.src2          = 4'd0;
    sb_if.use_src2      = 1'b0;
    sb_if.dest          = 4'd0;
    sb_if.dest_wb_en    = 1'b0;
    sb_if.write_back_en = 1'b0;
    sb_if.dest_wb       = 4'd0;
    sb_if.flush_valid   = 1'b0;
    sb_if.flush_dest    = 4'd0;
  endtask

  task automatic m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 1'b0;
  endtask

  function automatic bit m_hazard(int s);
    if (s >= 15) return 1'b0;
    if (m_cnt[s] == 0) return 1'b0;
    if (sb_if.write_back_en && int'(sb_if.dest_wb) == s &&
        m_cnt[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    int d;
    bit ovf;
    d = int'(sb_if.dest);
    ovf = 1'b0;
    if (sb_if.dest_wb_en && d < 15) begin
      if (m_cnt[d] == 3 &&
          !(sb_if.write_back_en && sb_if.dest_wb == sb_if.dest) &&
          !(sb_if.flush_valid && sb_if.flush_dest == sb_if.dest))
        ovf = 1'b1;
    end
    return sb_if.issue_valid &&
           (m_hazard(int'(sb_if.src1)) ||
            (sb_if.use_src2 && m_hazard(int'(sb_if.src2))) || ovf);
  endfunction

  function automatic logic [14:0] m_busy();
    logic [14:0] v;
    for (int i = 0; i < 15; i++) v[i] = (m_cnt[i] != 0);
    return v;
  endfunction

  function automatic logic [3:0] m_inflight();
    int s;
    s = 0;
    for (int i = 0; i < 15; i++) s += m_cnt[i];
    return (s > 15) ? 4'd15 : 4'(s);
  endfunction

  // Advance one clock and apply the same event to the model.
  task automatic tick();
    int n[15];
    bit ack;
    bit e;
    ack = sb_if.issue_valid && !m_stall();
    e = m_err;
    for (int i = 0; i < 15; i++) begin
      n[i] = m_cnt[i];
      if (ack && sb_if.dest_wb_en && int'(sb_if.dest) == i) n[i]++;
      if (sb_if.write_back_en && int'(sb_if.dest_wb) == i) n[i]--;
      if (sb_if.flush_valid && int'(sb_if.flush_dest) == i) n[i]--;
      if (n[i] < 0) begin
        n[i] = 0;
        e = 1'b1;
      end
    end
    @(posedge clk);
    m_cnt = n;
    m_err = e;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    m_reset();
    #1;
    n_checks += 5;
    if (sb_if.busy_mask !== 15'h0) begin
      n_errors++;
      $display("FAIL reset_busy: got %h expected 0", sb_if.busy_mask);
    end
    if (sb_if.inflight !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_inflight: got %h expected 0", sb_if.inflight);
    end
    if (sb_if.err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: got %b expected 0", sb_if.err_underflow);
    end
    if (sb_if.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stall: got %b expected 0", sb_if.stall);
    end
    if (sb_if.issue_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ack: got %b expected 0", sb_if.issue_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_issue();
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd1;
    sb_if.src2 = 4'd2;
    sb_if.use_src2 = 1'b1;
    sb_if.dest = 4'd3;
    sb_if.dest_wb_en = 1'b1;
    #1;
    n_checks += 2;
    if (sb_if.stall !== 1'b0 || sb_if.issue_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_ack: got stall=%b ack=%b expected 0/1",
               sb_if.stall, sb_if.issue_ack);
    end
    if (sb_if.busy_mask !== 15'h0) begin
      n_errors++;
      $display("FAIL basic_pre_busy: got %h expected 0", sb_if.busy_mask);
    end
    tick();
    clear_in();
    n_checks += 2;
    if (sb_if.busy_mask !== 15'h0008) begin
      n_errors++;
      $display("FAIL basic_busy: got %h expected 0008", sb_if.busy_mask);
    end
    if (sb_if.inflight !== 4'd1) begin
      n_errors++;
      $display("FAIL basic_inflight: got %0d expected 1", sb_if.inflight);
    end
  endtask

  task automatic test_raw_bypass();
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (sb_if.stall !== 1'b1 || sb_if.issue_ack !== 1'b0) begin
        n_errors++;
        $display("FAIL raw_stall: cycle %0d got stall=%b ack=%b expected 1/0",
                 c, sb_if.stall, sb_if.issue_ack);
      end
      tick();
    end
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd3;
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b0 || sb_if.issue_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL raw_bypass: got stall=%b ack=%b expected 0/1",
               sb_if.stall, sb_if.issue_ack);
    end
    tick();
    clear_in();
    n_checks += 2;
    if (sb_if.busy_mask !== 15'h0) begin
      n_errors++;
      $display("FAIL raw_busy: got %h expected 0", sb_if.busy_mask);
    end
    if (sb_if.inflight !== 4'd0) begin
      n_errors++;
      $display("FAIL raw_inflight: got %0d expected 0", sb_if.inflight);
    end
  endtask

  task automatic test_overflow();
    sb_if.issue_valid = 1'b1;
    sb_if.dest = 4'd5;
    sb_if.dest_wb_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (sb_if.issue_ack !== 1'b1) begin
        n_errors++;
        $display("FAIL ovf_fill: issue %0d got ack=%b expected 1",
                 c, sb_if.issue_ack);
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (sb_if.stall !== 1'b1) begin
        n_errors++;
        $display("FAIL ovf_stall: cycle %0d got %b expected 1",
                 c, sb_if.stall);
      end
      tick();
    end
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd5;
    #1;
    n_checks++;
    if (sb_if.issue_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_release: got ack=%b expected 1", sb_if.issue_ack);
    end
    tick();
    clear_in();
    n_checks += 2;
    if (sb_if.inflight !== 4'd3) begin
      n_errors++;
      $display("FAIL ovf_count: got %0d expected 3", sb_if.inflight);
    end
    if (sb_if.busy_mask !== 15'h0020) begin
      n_errors++;
      $display("FAIL ovf_busy: got %h expected 0020", sb_if.busy_mask);
    end
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd5;
    repeat (3) tick();
    clear_in();
    n_checks++;
    if (sb_if.inflight !== 4'd0 || sb_if.err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_drain: got inflight=%0d err=%b expected 0/0",
               sb_if.inflight, sb_if.err_underflow);
    end
  endtask

  task automatic test_same_cycle_net();
    sb_if.issue_valid = 1'b1;
    sb_if.dest = 4'd4;
    sb_if.dest_wb_en = 1'b1;
    tick();
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd4;
    #1;
    n_checks++;
    if (sb_if.issue_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL net_ack: got %b expected 1", sb_if.issue_ack);
    end
    tick();
    clear_in();
    n_checks += 2;
    if (sb_if.busy_mask !== 15'h0010) begin
      n_errors++;
      $display("FAIL net_busy: got %h expected 0010", sb_if.busy_mask);
    end
    if (sb_if.inflight !== 4'd1) begin
      n_errors++;
      $display("FAIL net_inflight: got %0d expected 1", sb_if.inflight);
    end
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd4;
    tick();
    clear_in();
  endtask

  task automatic test_pc_ignored();
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd15;
    sb_if.dest = 4'd15;
    sb_if.dest_wb_en = 1'b1;
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd15;
    sb_if.flush_valid = 1'b1;
    sb_if.flush_dest = 4'd15;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (sb_if.stall !== 1'b0 || sb_if.issue_ack !== 1'b1) begin
        n_errors++;
        $display("FAIL pc_stall: cycle %0d got stall=%b ack=%b expected 0/1",
                 c, sb_if.stall, sb_if.issue_ack);
      end
      tick();
      n_checks++;
      if (sb_if.busy_mask !== 15'h0 || sb_if.inflight !== 4'd0 ||
          sb_if.err_underflow !== 1'b0) begin
        n_errors++;
        $display("FAIL pc_state: got busy=%h infl=%0d err=%b expected 0/0/0",
                 sb_if.busy_mask, sb_if.inflight, sb_if.err_underflow);
      end
    end
    clear_in();
  endtask

  task automatic test_flush_underflow();
    sb_if.issue_valid = 1'b1;
    sb_if.dest = 4'd7;
    sb_if.dest_wb_en = 1'b1;
    tick();
    clear_in();
    n_checks++;
    if (sb_if.inflight !== 4'd1) begin
      n_errors++;
      $display("FAIL flush_pre: got %0d expected 1", sb_if.inflight);
    end
    sb_if.flush_valid = 1'b1;
    sb_if.flush_dest = 4'd7;
    tick();
    clear_in();
    n_checks++;
    if (sb_if.inflight !== 4'd0 || sb_if.busy_mask !== 15'h0 ||
        sb_if.err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_clear: got infl=%0d busy=%h err=%b expected 0/0/0",
               sb_if.inflight, sb_if.busy_mask, sb_if.err_underflow);
    end
    sb_if.write_back_en = 1'b1;
    sb_if.dest_wb = 4'd7;
    tick();
    clear_in();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (sb_if.err_underflow !== 1'b1 || sb_if.inflight !== 4'd0) begin
        n_errors++;
        $display("FAIL flush_underflow: cycle %0d got err=%b infl=%0d expected 1/0",
                 c, sb_if.err_underflow, sb_if.inflight);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    sb_if.issue_valid = 1'b1;
    sb_if.dest_wb_en = 1'b1;
    sb_if.dest = 4'd2;
    tick();
    sb_if.dest = 4'd6;
    tick();
    clear_in();
    sb_if.issue_valid = 1'b1;
    sb_if.src1 = 4'd2;
    #1;
    n_checks++;
    if (sb_if.stall !== 1'b1 || sb_if.inflight !== 4'd2) begin
      n_errors++;
      $display("FAIL mrst_pre: got stall=%b infl=%0d expected 1/2",
               sb_if.stall, sb_if.inflight);
    end
    rst = 1'b1;
    m_reset();
    #1;
    n_checks++;
    if (sb_if.busy_mask !== 15'h0 || sb_if.inflight !== 4'd0 ||
        sb_if.err_underflow !== 1'b0 || sb_if.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL mrst_clear: got busy=%h infl=%0d err=%b stall=%b expected 0",
               sb_if.busy_mask, sb_if.inflight, sb_if.err_underflow,
               sb_if.stall);
    end
    clear_in();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int busy_q[$];
    bit exp_stall;
    for (int c = 0; c < 400; c++) begin
      busy_q.delete();
      for (int i = 0; i < 15; i++) if (m_cnt[i] != 0) busy_q.push_back(i);
      sb_if.issue_valid = ($urandom_range(0, 9) < 7);
      sb_if.src1 = 4'($urandom_range(0, 15));
      sb_if.src2 = 4'($urandom_range(0, 15));
      sb_if.use_src2 = 1'($urandom);
      sb_if.dest = 4'($urandom_range(0, 15));
      sb_if.dest_wb_en = ($urandom_range(0, 9) < 8);
      sb_if.write_back_en = ($urandom_range(0, 9) < 4);
      if (busy_q.size() > 0 && $urandom_range(0, 9) < 9)
        sb_if.dest_wb = 4'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        sb_if.dest_wb = 4'($urandom_range(0, 15));
      sb_if.flush_valid = ($urandom_range(0, 9) == 0);
      if (busy_q.size() > 0)
        sb_if.flush_dest = 4'(busy_q[$urandom_range(0, busy_q.size() - 1)]);
      else
        sb_if.flush_dest = 4'($urandom_range(0, 15));
      #1;
      exp_stall = m_stall();
      n_checks++;
      if (sb_if.stall !== exp_stall ||
          sb_if.issue_ack !== (sb_if.issue_valid && !exp_stall)) begin
        n_errors++;
        $display("FAIL rand_stall: cycle %0d got stall=%b ack=%b expected stall=%b",
                 c, sb_if.stall, sb_if.issue_ack, exp_stall);
      end
      tick();
      n_checks++;
      if (sb_if.busy_mask !== m_busy() || sb_if.inflight !== m_inflight() ||
          sb_if.err_underflow !== m_err) begin
        n_errors++;
        $display("FAIL rand_state: cycle %0d got busy=%h infl=%0d err=%b expected %h/%0d/%b",
                 c, sb_if.busy_mask, sb_if.inflight, sb_if.err_underflow,
                 m_busy(), m_inflight(), m_err);
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_bypass();
    test_overflow();
    test_same_cycle_net();
    test_pc_ignored();
    test_flush_underflow();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks outstanding register writes between ID and WB for the 15-entry register file (R0-R14); stalls issue in ID while an operand register still has an older write in flight.
- Sits beside the register file in the ID stage.
- Driven by the ID issue request, the WB write-back port and the EXE flush path.
- Replaces per-stage destination comparison with per-register pending counters.

Parameters:
- NUM_REGS, 15, tracked registers R0..NUM_REGS-1; index 15 (PC) is never tracked.
- CNT_W, 2, width of each pending counter.
- MAX_INFLIGHT, 3, maximum pending writes per register (must be <= 2^CNT_W-1).
- WB_BYPASS, 1, 1 = a write-back in the current cycle clears the hazard for a same-cycle read (the register file writes on negedge).

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  ID has an instruction wanting to issue.
- src1  in  4  first operand register.
- src2  in  4  second operand register.
- use_src2  in  1  src2 is a real operand.
- dest  in  4  destination register of the issuing instruction.
- dest_wb_en  in  1  issuing instruction will write dest.
- write_back_en  in  1  WB is writing this cycle.
- dest_wb  in  4  WB destination register.
- flush_valid  in  1  one in-flight instruction is squashed this cycle.
- flush_dest  in  4  destination of the squashed instruction (only sent if it had wb enabled).
- stall  out  1  ID must hold; combinational.
- issue_ack  out  1  issue accepted this cycle = issue_valid & ~stall.
- busy_mask  out  15  registered; bit i = count[i] != 0.
- inflight  out  4  registered total of all counters, saturating at 15.
- err_underflow  out  1  sticky; a decrement hit a zero counter.

Behaviour:
- Reset (async, immediate): all count[i]=0, busy_mask=0, inflight=0, err_underflow=0. With issue_valid=0, stall=0 and issue_ack=0.
- Hazard for operand s:
  - s<15 and count[s]!=0, except when WB_BYPASS=1, write_back_en=1, dest_wb==s and count[s]==1.
  - src2 is checked only when use_src2=1.
  - s==15 is never a hazard.
- Overflow stall: dest_wb_en=1, dest<15 and count[dest]==MAX_INFLIGHT, and no same-cycle decrement on dest.
- stall = issue_valid & (hazard1 | hazard2 | overflow). Purely combinational from the current counters and inputs.
- Per-register update at posedge: next = count + inc - dec_wb - dec_fl.
  - inc = issue_ack & dest_wb_en & (dest==i).
  - dec_wb = write_back_en & (dest_wb==i).
  - dec_fl = flush_valid & (flush_dest==i).
- Simultaneous events on the same register are netted in one cycle, e.g. inc+dec_wb leaves the count unchanged.
- Indices >=15 on dest, dest_wb or flush_dest are ignored entirely: no count change, no error.
- Underflow:
  - If the decrements exceed count+inc, the counter clamps at 0 and err_underflow sets.
  - err_underflow clears only on rst.
- Counters never exceed MAX_INFLIGHT; the overflow stall guarantees this.
- busy_mask and inflight reflect post-update counters, one cycle after the event.
- Latency:
  - A write issued at cycle t blocks a dependent read at t+1.
  - The block is released in the WB cycle (bypass) or the cycle after (WB_BYPASS=0).
- Reset mid-operation clears all counters; in-flight write-backs arriving afterwards trigger underflow only if they were not squashed. The pipeline must flush alongside rst.

Test Plan:
- Reset, then issue src1=1, src2=2, dest=3, dest_wb_en=1 -> issue_ack=1, stall=0; next cycle busy_mask=0x0008, inflight=1.
- Issue a read of src1=3 while count[3]=1 -> stall=1 every cycle. In the cycle with write_back_en=1, dest_wb=3: stall=0 (WB_BYPASS=1); next cycle busy_mask=0.
- Three back-to-back issues with dest=5, then a fourth -> first three acked (count[5]=3); fourth stalls until a WB to 5 arrives in the same cycle, then it is acked and count stays 3.
- In one cycle, issue dest=4 while WB dest_wb=4 with count[4]=1 -> count[4] remains 1 and busy bit 4 stays set.
- Flush: count[7]=1, flush_valid=1, flush_dest=7 -> count[7]=0, inflight decrements. A following write_back_en with dest_wb=7 -> err_underflow=1 and stays 1 until rst.
- src1=15, use_src2=0, dest=15 with issue_valid -> never stalls and no counter changes. Assert rst mid-stream with counts nonzero -> all outputs 0 immediately.
